keypad_controller: RTL and testbench

Input-side counterpart to the 4-digit seven-segment display path: scans a 4x4 hex keypad by driving one column low at a time and sampling the rows. It debounces each press and emits one hex code per press. Each accepted digit is shifted into a 16-bit entry register that drives the display controller's `seg` input directly, so entered digits scroll in from the right.

---
 rtl/keypad_controller.sv | 140 ++++++++++++++
 tb/tb_keypad_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_controller.sv
// 4x4 hex keypad scanner: walks one active-low column at a time, debounces a single-key press,
// and shifts each accepted hex code into a 16-bit entry register for the seven-segment display.
module keypad_controller #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] value
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [3:0]      row_meta, rs;
  logic [3:0]      rl, rl_next;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [1:0]      ci, ci_next;
  logic [CW-1:0]   deb_cnt, deb_next;
  logic            deb_last;
  logic            accept;
  logic            one_low;
  logic [1:0]      r_idx;
  logic [3:0]      code;

  assign tick     = (tick_cnt == TW'(SCAN_DIV - 1));
  assign deb_last = (deb_cnt == CW'(DEBOUNCE - 1));
  assign code     = {r_idx, ci};

  // A press is only valid when exactly one row is pulled low; anything else is ghosting or noise.
  always_comb begin
    one_low = 1'b0;
    r_idx   = 2'd0;
    case (rl)
      4'b1110: begin one_low = 1'b1; r_idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; r_idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; r_idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; r_idx = 2'd3; end
      default: begin one_low = 1'b0; r_idx = 2'd0; end
    endcase
  end

  // key_valid is a one-cycle strobe with no backpressure; key_code holds until the next accept.
  always_comb begin
    state_next = state;
    ci_next    = ci;
    rl_next    = rl;
    deb_next   = deb_cnt;
    accept     = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (rs == 4'hF) begin
            ci_next = ci + 2'd1;
          end else begin
            rl_next    = rs;
            deb_next   = '0;
            state_next = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (rs == rl && one_low) begin
            if (deb_last) begin
              accept     = 1'b1;
              deb_next   = '0;
              state_next = ST_HOLD;
            end else begin
              deb_next = deb_cnt + 1'b1;
            end
          end else begin
            deb_next   = '0;
            ci_next    = ci + 2'd1;
            state_next = ST_SCAN;
          end
        end
        ST_HOLD: begin
          if (rs == 4'hF) begin
            if (deb_last) begin
              deb_next   = '0;
              ci_next    = ci + 2'd1;
              state_next = ST_SCAN;
            end else begin
              deb_next = deb_cnt + 1'b1;
            end
          end else begin
            deb_next = '0;
          end
        end
        default: begin
          deb_next   = '0;
          state_next = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_meta  <= 4'hF;
      rs        <= 4'hF;
      tick_cnt  <= '0;
      state     <= ST_SCAN;
      ci        <= 2'd0;
      rl        <= 4'hF;
      deb_cnt   <= '0;
      col       <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      value     <= 16'h0000;
    end else begin
      row_meta  <= row;
      rs        <= row_meta;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      state     <= state_next;
      ci        <= ci_next;
      rl        <= rl_next;
      deb_cnt   <= deb_next;
      col       <= ~(4'b0001 << ci_next);
      key_valid <= accept;
      if (accept) key_code <= code;
      // clr wins over a same-edge accept on the entry register only.
      if (clr) value <= 16'h0000;
      else if (accept) value <= {value[11:0], code};
    end
  end

endmodule

// File: tb/tb_keypad_controller.sv
// Bench for keypad_controller: keypad model on row/col, expected-result queue popped on key_valid.
module tb_keypad_controller;

  logic        clk;
  logic        reset;
  logic [3:0]  row;
  logic        clr;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] value;

  logic [15:0] press_mask;
  logic [15:0] exp_val;
  logic [19:0] exp_q[$];
  int          errors;
  int          checks;
  int          pulse_cnt;

  int seq_r [4] = '{0, 0, 0, 1};
  int seq_c [4] = '{1, 2, 3, 0};
  logic [3:0] col_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  keypad_controller #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .clr       (clr),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .value     (value)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad: a pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (key_valid) begin
      logic [19:0] e;
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("key_code", {28'd0, key_code}, {28'd0, e[3:0]});
        check("value", {16'd0, value}, {16'd0, e[19:4]});
      end
    end
  end

  task automatic expect_key(input int r, input int c);
    logic [3:0] k;
    k = 4'(4*r + c);
    exp_val = {exp_val[11:0], k};
    exp_q.push_back({exp_val, k});
  endtask

  task automatic wait_pulse(input int start);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (pulse_cnt != start) got = 1'b1;
    end
    check("accept_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic press_key(input int r, input int c);
    int start;
    start = pulse_cnt;
    expect_key(r, c);
    press_mask[4*r+c] = 1'b1;
    wait_pulse(start);
  endtask

  task automatic release_key();
    press_mask = '0;
    repeat (40) @(negedge clk);
  endtask

  task automatic wait_col_enter(input logic [3:0] target);
    logic [3:0] prev;
    bit got;
    got  = 1'b0;
    prev = col;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (col == target && prev != target) got = 1'b1;
      prev = col;
    end
    check("col_enter_timeout", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int start, n, changes;
    bit done;
    logic [3:0] c0;
    errors = 0; checks = 0; pulse_cnt = 0;
    press_mask = '0; exp_val = '0; clr = 1'b0; reset = 1'b0;

    // reset and idle scan
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_col", {28'd0, col}, 32'b1110);
    check("rst_value", {16'd0, value}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("scan_col", {28'd0, col}, {28'd0, col_seq[k]});
    end

    // single press r1c2, long hold, release
    press_key(1, 2);
    start = pulse_cnt;
    repeat (400) @(negedge clk);
    check("no_repeat", pulse_cnt, start);
    check("hold_col", {28'd0, col}, 32'b1011);
    press_mask = '0;
    n = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      n++;
      if (col != 4'b1011) done = 1'b1;
    end
    check("resume_cycles", {31'd0, (done && n >= 9 && n <= 16)}, 32'd1);
    check("resume_col", {28'd0, col}, 32'b0111);
    repeat (20) @(negedge clk);

    // sequence 1,2,3,4 then F
    for (int k = 0; k < 4; k++) begin
      press_key(seq_r[k], seq_c[k]);
      release_key();
    end
    check("seq_value", {16'd0, value}, 32'h1234);
    press_key(3, 3);
    release_key();
    check("fifth_value", {16'd0, value}, 32'h234F);

    // bounce: press visible for two ticks only
    wait_col_enter(4'b1110);
    start = pulse_cnt;
    press_mask[8] = 1'b1;
    repeat (8) @(negedge clk);
    press_mask = '0;
    repeat (40) @(negedge clk);
    check("bounce_no_pulse", pulse_cnt, start);
    check("bounce_value", {16'd0, value}, {16'd0, exp_val});
    c0 = col;
    repeat (5) @(negedge clk);
    check("bounce_scan", {31'd0, (col != c0)}, 32'd1);

    // ghosting: rows 0 and 2 low together on column 1
    start = pulse_cnt; changes = 0;
    press_mask[1] = 1'b1;
    press_mask[9] = 1'b1;
    c0 = col;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (col != c0) changes++;
      c0 = col;
    end
    release_key();
    check("ghost_no_pulse", pulse_cnt, start);
    check("ghost_value", {16'd0, value}, {16'd0, exp_val});
    check("ghost_scanning", {31'd0, (changes > 0)}, 32'd1);

    // reset after two matching ticks of r0c2
    wait_col_enter(4'b1011);
    start = pulse_cnt;
    press_mask[2] = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_col", {28'd0, col}, 32'b1110);
    check("mid_rst_value", {16'd0, value}, 32'd0);
    check("mid_rst_code", {28'd0, key_code}, 32'd0);
    check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_no_pulse", pulse_cnt, start);
    exp_val = '0;
    expect_key(0, 2);
    reset = 1'b1;
    wait_pulse(start);
    repeat (120) @(negedge clk);
    check("redetect_once", pulse_cnt, start + 1);
    release_key();

    // rebuild 1234, then clr on the accept edge of code 5
    for (int k = 0; k < 4; k++) begin
      press_key(seq_r[k], seq_c[k]);
      release_key();
    end
    check("rebuild_value", {16'd0, value}, 32'h1234);
    wait_col_enter(4'b1101);
    start = pulse_cnt;
    exp_q.push_back({16'h0000, 4'h5});
    exp_val = '0;
    press_mask[5] = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_valid", {31'd0, key_valid}, 32'd1);
    check("clr_code", {28'd0, key_code}, 32'd5);
    check("clr_value", {16'd0, value}, 32'd0);
    release_key();
    check("clr_one_pulse", pulse_cnt, start + 1);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
